ycr_ahb_arb2: RTL and testbench
===============================

Name: ycr_ahb_arb2

Overview:
- Two-master AHB-Lite arbiter. Shares one AHB slave port (core-to-system bus) between the DMEM bridge (master 0) and the IMEM bridge (master 1).
- Each master has an input stage. The stage absorbs an address phase the shared bus cannot take this cycle, so neither master ever sees a split or corrupted transfer.
- Sits between the ycr_imem_ahb / dmem AHB bridges and the top-level AHB port.

Parameters:
- MAX_CONSEC, 4: maximum consecutive master-0 grants while master 1 is pending. After this, master 1 is forced one grant.
- CNT_W, $clog2(MAX_CONSEC+1): width of the consecutive-grant counter.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active high
- m_htrans  input  [1:0][1:0]  per-master HTRANS. Index 0 = DMEM, 1 = IMEM. Only IDLE and NONSEQ are legal.
- m_haddr  input  [1:0][YCR_AHB_WIDTH-1:0]  per-master address
- m_hwrite  input  [1:0]  per-master write flag
- m_hsize  input  [1:0][2:0]  per-master size
- m_hprot  input  [1:0][3:0]  per-master protection
- m_hwdata  input  [1:0][YCR_AHB_WIDTH-1:0]  per-master write data, valid in that master's data phase
- m_hready  output  [1:0]  per-master HREADY
- m_hresp  output  [1:0]  per-master HRESP
- m_hrdata  output  [1:0][YCR_AHB_WIDTH-1:0]  per-master read data. The slave hrdata is broadcast to both masters.
- htrans, haddr, hwrite, hsize, hprot  output  2 / YCR_AHB_WIDTH / 1 / 3 / 4  shared slave address phase
- hburst  output  3  constant YCR_HBURST_SINGLE
- hmastlock  output  1  constant 0
- hwdata  output  YCR_AHB_WIDTH  shared write data
- hready  input  1  slave HREADY
- hresp  input  1  slave HRESP
- hrdata  input  YCR_AHB_WIDTH  slave read data

Behaviour:
Input stage, per master x:
- Registers: hold_vld[x] and hold_ctrl[x] (haddr, hwrite, hsize, hprot).
- m_hready[x] = 0 when hold_vld[x].
- Otherwise, m_hready[x] = hready when dp_vld & dp_own==x.
- Otherwise, m_hready[x] = 1.
- A live request is m_hready[x] & m_htrans[x]==NONSEQ. If it is not issued directly to the bus in that cycle, it is captured into hold_ctrl[x] and hold_vld[x] is set.
- req[x] = hold_vld[x] | live request.

Arbitration:
- Grant decisions are combinational when hready=1.
- Master 0 wins unless cnt==MAX_CONSEC and req[1].
- The grant source for master x is the hold register when hold_vld[x], else the live master signals.
- When hready=0 and htrans=NONSEQ is being driven, grant and source are locked (registered). The address phase stays stable until accepted.
- cnt: increments on each accepted master-0 grant while req[1]. Clears on any master-1 grant. Clears when req[1]=0.

Bus drive:
- htrans = NONSEQ when any grant is active, else IDLE. The address/control mux selects the granted source.
- Address phase accepted (hready=1 & NONSEQ): dp_vld <= 1, dp_own <= granted index, hold_vld[granted] <= 0.
- If there is no accepted transfer and hready=1: dp_vld <= 0.

Data phase:
- hwdata = m_hwdata[dp_own].
- m_hresp[dp_own] = hresp. The other master sees OKAY.
- A two-cycle ERROR is passed through unchanged. Subsequent holds are not cancelled.

Simultaneous events:
- Both live in the same cycle: the winner goes direct, the loser is captured in its hold.
- Hold and live on the same master cannot coexist, because m_hready=0 while the hold is set.

Reset (rst=1, async):
- hold_vld=0, dp_vld=0, cnt=0.
- Outputs: htrans=IDLE, m_hready=2'b11, m_hresp=OKAY.
- Reset mid-transfer discards holds and the data phase owner.

Latency:
- Uncontended: zero added cycles.
- Contended: loser waits at least one extra address phase.

Decomposition:
- YCR_AHB_WIDTH, HTRANS/HRESP/HBURST/HSIZE encodings and the hold-control struct type go in shared package ycr_ahb_pkg.
- Sub-module ycr_ahb_arb_in_stage, instantiated twice: hold register plus m_hready generation.

Test Plan:
- Single master 1 reads 0x100, 0x104 back-to-back with hready=1 → htrans NONSEQ in consecutive cycles; m_hready[1] never 0; hrdata returned with no added cycles.
- Both masters NONSEQ in the same cycle (m0 write 0x2000 data 0xA5A5A5A5; m1 read 0x300) → m0 issued first; m1 captured in hold; m_hready[1]=0 one cycle; 0x300 issued next cycle; hwdata=0xA5A5A5A5 during m0 data phase.
- Master 0 streams continuously with master 1 pending, MAX_CONSEC=4 → exactly 4 m0 grants, then one m1 grant, then m0 resumes; cnt resets.
- Slave inserts 2 wait states (hready=0) on held m1 address 0x400 → haddr/htrans stable all 3 cycles; no grant change.
- Slave returns ERROR on m0 data phase → m_hresp[0]=1 for 2 cycles; m_hresp[1]=0; a pending m1 hold is issued afterwards.
- rst asserted during a contended m1 hold → immediately htrans=IDLE, m_hready=2'b11; no stale 0x400 issued after release.

Source files
------------

// File: rtl/ycr_ahb_pkg.sv
// Shared AHB-Lite definitions for the YCR core-to-system bus arbiter:
// bus width, transfer/response/burst/size encodings and the parked control record.
package ycr_ahb_pkg;

  localparam int YCR_AHB_WIDTH = 32;

  typedef enum logic [1:0] {
    YCR_HTRANS_IDLE   = 2'b00,
    YCR_HTRANS_BUSY   = 2'b01,
    YCR_HTRANS_NONSEQ = 2'b10,
    YCR_HTRANS_SEQ    = 2'b11
  } ycr_htrans_e;

  typedef enum logic {
    YCR_HRESP_OKAY  = 1'b0,
    YCR_HRESP_ERROR = 1'b1
  } ycr_hresp_e;

  localparam logic [2:0] YCR_HBURST_SINGLE = 3'b000;

  localparam logic [2:0] YCR_HSIZE_8BIT  = 3'b000;
  localparam logic [2:0] YCR_HSIZE_16BIT = 3'b001;
  localparam logic [2:0] YCR_HSIZE_32BIT = 3'b010;

  typedef struct packed {
    logic [YCR_AHB_WIDTH-1:0] haddr;
    logic                     hwrite;
    logic [2:0]               hsize;
    logic [3:0]               hprot;
  } ycr_ahb_ctrl_t;

endpackage

// File: rtl/ycr_ahb_arb_in_stage.sv
// Per-master input stage: parks an address phase the shared bus could not
// take this cycle and generates that master's HREADY.
module ycr_ahb_arb_in_stage
  import ycr_ahb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    htrans_i,
  input  ycr_ahb_ctrl_t ctrl_i,
  input  logic          hready_i,
  input  logic          dp_own_i,
  input  logic          accept_i,
  output logic          hready_o,
  output logic          live_o,
  output logic          hold_vld_o,
  output ycr_ahb_ctrl_t hold_ctrl_o
);

  logic          hold_vld_q;
  logic          hold_vld_d;
  ycr_ahb_ctrl_t hold_ctrl_q;
  ycr_ahb_ctrl_t hold_ctrl_d;

  // A parked request stalls the master until the bus takes it.
  always_comb begin
    if (hold_vld_q) begin
      hready_o = 1'b0;
    end else if (dp_own_i) begin
      hready_o = hready_i;
    end else begin
      hready_o = 1'b1;
    end
  end

  assign live_o      = hready_o & (htrans_i == YCR_HTRANS_NONSEQ);
  assign hold_vld_o  = hold_vld_q;
  assign hold_ctrl_o = hold_ctrl_q;

  always_comb begin
    hold_vld_d  = hold_vld_q;
    hold_ctrl_d = hold_ctrl_q;
    if (accept_i) begin
      hold_vld_d = 1'b0;
    end else if (live_o) begin
      hold_vld_d  = 1'b1;
      hold_ctrl_d = ctrl_i;
    end else begin
      hold_vld_d = hold_vld_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_vld_q  <= 1'b0;
      hold_ctrl_q <= '0;
    end else begin
      hold_vld_q  <= hold_vld_d;
      hold_ctrl_q <= hold_ctrl_d;
    end
  end

endmodule

// File: rtl/ycr_ahb_arb2.sv
// Two-master AHB-Lite arbiter: DMEM bridge (master 0) and IMEM bridge (master 1)
// share one slave port; master 0 has priority with a bounded streak.
module ycr_ahb_arb2
  import ycr_ahb_pkg::*;
#(
  parameter int MAX_CONSEC = 4,
  parameter int CNT_W      = $clog2(MAX_CONSEC + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0][1:0]               m_htrans,
  input  logic [1:0][YCR_AHB_WIDTH-1:0] m_haddr,
  input  logic [1:0]                    m_hwrite,
  input  logic [1:0][2:0]               m_hsize,
  input  logic [1:0][3:0]               m_hprot,
  input  logic [1:0][YCR_AHB_WIDTH-1:0] m_hwdata,
  output logic [1:0]                    m_hready,
  output logic [1:0]                    m_hresp,
  output logic [1:0][YCR_AHB_WIDTH-1:0] m_hrdata,
  output logic [1:0]                    htrans,
  output logic [YCR_AHB_WIDTH-1:0]      haddr,
  output logic                          hwrite,
  output logic [2:0]                    hsize,
  output logic [3:0]                    hprot,
  output logic [2:0]                    hburst,
  output logic                          hmastlock,
  output logic [YCR_AHB_WIDTH-1:0]      hwdata,
  input  logic                          hready,
  input  logic                          hresp,
  input  logic [YCR_AHB_WIDTH-1:0]      hrdata
);

  logic [1:0]          live;
  logic [1:0]          hold_vld;
  logic [1:0]          req;
  logic [1:0]          accept;
  ycr_ahb_ctrl_t [1:0] hold_ctrl;
  ycr_ahb_ctrl_t [1:0] live_ctrl;
  ycr_ahb_ctrl_t       gnt_ctrl;
  logic                gnt_vld;
  logic                gnt_idx;
  logic                bus_accept;
  logic                dp_vld_q;
  logic                dp_own_q;
  logic                lock_vld_q;
  logic                lock_idx_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;

  for (genvar i = 0; i < 2; i++) begin : g_in
    assign live_ctrl[i] = '{haddr: m_haddr[i], hwrite: m_hwrite[i],
                            hsize: m_hsize[i], hprot: m_hprot[i]};

    ycr_ahb_arb_in_stage u_in (
      .clk         (clk),
      .rst         (rst),
      .htrans_i    (m_htrans[i]),
      .ctrl_i      (live_ctrl[i]),
      .hready_i    (hready),
      .dp_own_i    (dp_vld_q & (dp_own_q == 1'(i))),
      .accept_i    (accept[i]),
      .hready_o    (m_hready[i]),
      .live_o      (live[i]),
      .hold_vld_o  (hold_vld[i]),
      .hold_ctrl_o (hold_ctrl[i])
    );
  end

  assign req = hold_vld | live;

  // A stalled address phase keeps its owner until the slave takes it.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 1'b0;
    if (rst) begin
      gnt_vld = 1'b0;
      gnt_idx = 1'b0;
    end else if (lock_vld_q) begin
      gnt_vld = 1'b1;
      gnt_idx = lock_idx_q;
    end else if (req[0] & ~((cnt_q == CNT_W'(MAX_CONSEC)) & req[1])) begin
      gnt_vld = 1'b1;
      gnt_idx = 1'b0;
    end else if (req[1]) begin
      gnt_vld = 1'b1;
      gnt_idx = 1'b1;
    end else begin
      gnt_vld = 1'b0;
      gnt_idx = 1'b0;
    end
  end

  assign gnt_ctrl   = hold_vld[gnt_idx] ? hold_ctrl[gnt_idx] : live_ctrl[gnt_idx];
  assign bus_accept = gnt_vld & hready;
  assign accept     = {bus_accept & gnt_idx, bus_accept & ~gnt_idx};

  assign htrans    = gnt_vld ? YCR_HTRANS_NONSEQ : YCR_HTRANS_IDLE;
  assign haddr     = gnt_ctrl.haddr;
  assign hwrite    = gnt_ctrl.hwrite;
  assign hsize     = gnt_ctrl.hsize;
  assign hprot     = gnt_ctrl.hprot;
  assign hburst    = YCR_HBURST_SINGLE;
  assign hmastlock = 1'b0;
  assign hwdata    = m_hwdata[dp_own_q];
  assign m_hrdata  = {hrdata, hrdata};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      if (dp_vld_q & (dp_own_q == 1'(i))) begin
        m_hresp[i] = hresp;
      end else begin
        m_hresp[i] = YCR_HRESP_OKAY;
      end
    end
  end

  // Streak of master-0 grants taken while master 1 is waiting.
  always_comb begin
    cnt_d = cnt_q;
    if (!req[1]) begin
      cnt_d = '0;
    end else if (bus_accept & gnt_idx) begin
      cnt_d = '0;
    end else if (bus_accept & (cnt_q != CNT_W'(MAX_CONSEC))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_vld_q   <= 1'b0;
      dp_own_q   <= 1'b0;
      lock_vld_q <= 1'b0;
      lock_idx_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      cnt_q      <= cnt_d;
      lock_vld_q <= ~hready & gnt_vld;
      lock_idx_q <= gnt_idx;
      if (hready) begin
        dp_vld_q <= gnt_vld;
        if (gnt_vld) begin
          dp_own_q <= gnt_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_ycr_ahb_arb2.sv
// Self-checking bench for ycr_ahb_arb2: directed vector table, hand-written
// fairness/reset sequences and a randomized run against a reference model.
module tb_ycr_ahb_arb2;
  import ycr_ahb_pkg::*;

  localparam int         W    = YCR_AHB_WIDTH;
  localparam int         MAXC = 4;
  localparam int         NV   = 15;
  localparam logic [1:0] NS   = 2'b10;
  localparam logic [1:0] ID   = 2'b00;

  typedef struct {
    logic [1:0]   t0;
    logic [W-1:0] a0;
    logic         w0;
    logic [W-1:0] d0;
    logic [1:0]   t1;
    logic [W-1:0] a1;
    logic         hr;
    logic         hrs;
    logic [1:0]   e_trans;
    logic [W-1:0] e_addr;
    logic [1:0]   e_rdy;
    logic [1:0]   e_resp;
    logic         chk_wd;
    logic [W-1:0] e_wd;
  } vec_t;

  typedef struct {
    logic [1:0]   t;
    logic [W-1:0] a;
    logic         w;
    logic [2:0]   s;
    logic [3:0]   p;
    logic [W-1:0] d;
  } mreq_t;

  logic              clk;
  logic              rst;
  logic [1:0][1:0]   m_htrans;
  logic [1:0][W-1:0] m_haddr;
  logic [1:0]        m_hwrite;
  logic [1:0][2:0]   m_hsize;
  logic [1:0][3:0]   m_hprot;
  logic [1:0][W-1:0] m_hwdata;
  logic [1:0]        m_hready;
  logic [1:0]        m_hresp;
  logic [1:0][W-1:0] m_hrdata;
  logic [1:0]        htrans;
  logic [W-1:0]      haddr;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [3:0]        hprot;
  logic [2:0]        hburst;
  logic              hmastlock;
  logic [W-1:0]      hwdata;
  logic              hready;
  logic              hresp;
  logic [W-1:0]      hrdata;

  int n_chk;
  int n_fail;

  vec_t         vt [NV];
  mreq_t        cur [2];
  mreq_t        held_c [2];
  mreq_t        src;
  bit           held [2];
  bit           adv [2];
  bit           live [2];
  bit           want [2];
  logic [1:0]   e_rdy;
  logic [W-1:0] nxt_wd [2];
  int           busy;
  int           lock;
  int           streak;
  int           win;
  bit           took;

  ycr_ahb_arb2 #(.MAX_CONSEC(MAXC)) dut (
    .clk       (clk),
    .rst       (rst),
    .m_htrans  (m_htrans),
    .m_haddr   (m_haddr),
    .m_hwrite  (m_hwrite),
    .m_hsize   (m_hsize),
    .m_hprot   (m_hprot),
    .m_hwdata  (m_hwdata),
    .m_hready  (m_hready),
    .m_hresp   (m_hresp),
    .m_hrdata  (m_hrdata),
    .htrans    (htrans),
    .haddr     (haddr),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hprot     (hprot),
    .hburst    (hburst),
    .hmastlock (hmastlock),
    .hwdata    (hwdata),
    .hready    (hready),
    .hresp     (hresp),
    .hrdata    (hrdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_m(input int x, input logic [1:0] t, input logic [W-1:0] a,
                         input logic w, input logic [W-1:0] d);
    m_htrans[x] = t;
    m_haddr[x]  = a;
    m_hwrite[x] = w;
    m_hsize[x]  = 3'b010;
    m_hprot[x]  = 4'b0011;
    m_hwdata[x] = d;
  endtask

  function automatic vec_t mk(input logic [1:0] t0, input logic [W-1:0] a0, input logic w0,
                              input logic [W-1:0] d0, input logic [1:0] t1, input logic [W-1:0] a1,
                              input logic hr, input logic hrs, input logic [1:0] et,
                              input logic [W-1:0] ea, input logic [1:0] er, input logic [1:0] ep,
                              input logic cw, input logic [W-1:0] ew);
    vec_t v;
    v.t0 = t0; v.a0 = a0; v.w0 = w0; v.d0 = d0; v.t1 = t1; v.a1 = a1;
    v.hr = hr; v.hrs = hrs; v.e_trans = et; v.e_addr = ea; v.e_rdy = er;
    v.e_resp = ep; v.chk_wd = cw; v.e_wd = ew;
    return v;
  endfunction

  // Master 0 streams while master 1 asks once: 4 master-0 grants, then master 1.
  task automatic stream(input logic [W-1:0] base, input logic [W-1:0] m1a);
    logic [W-1:0] a0;
    logic [W-1:0] exp_a;
    logic         m1p;
    a0  = base;
    m1p = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      drive_m(0, NS, a0, 1'b1, a0 ^ 32'hFFFF_0000);
      drive_m(1, m1p ? NS : ID, m1a, 1'b0, 32'h0);
      hready = 1'b1;
      hresp  = 1'b0;
      #1;
      if (c < 4)       exp_a = base + W'(4 * c);
      else if (c == 4) exp_a = m1a;
      else             exp_a = base + W'(4 * (c - 1));
      chk($sformatf("stream c%0d htrans", c), htrans, NS);
      chk($sformatf("stream c%0d haddr", c), haddr, exp_a);
      chk($sformatf("stream c%0d m_hready", c), m_hready, {(c == 0 || c >= 5), (c != 5)});
      if (m_hready[0]) a0 = a0 + 32'h4;
      if (m_hready[1]) m1p = 1'b0;
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;

    vt[0]  = mk(ID, 32'h0,    1'b0, 32'h0,        NS, 32'h100, 1'b1, 1'b0, NS, 32'h100,  2'b11, 2'b00, 1'b0, 32'h0);
    vt[1]  = mk(ID, 32'h0,    1'b0, 32'h0,        NS, 32'h104, 1'b1, 1'b0, NS, 32'h104,  2'b11, 2'b00, 1'b0, 32'h0);
    vt[2]  = mk(ID, 32'h0,    1'b0, 32'h0,        ID, 32'h0,   1'b1, 1'b0, ID, 32'h0,    2'b11, 2'b00, 1'b0, 32'h0);
    vt[3]  = mk(NS, 32'h2000, 1'b1, 32'h0,        NS, 32'h300, 1'b1, 1'b0, NS, 32'h2000, 2'b11, 2'b00, 1'b0, 32'h0);
    vt[4]  = mk(ID, 32'h0,    1'b0, 32'hA5A5A5A5, ID, 32'h0,   1'b1, 1'b0, NS, 32'h300,  2'b01, 2'b00, 1'b1, 32'hA5A5A5A5);
    vt[5]  = mk(ID, 32'h0,    1'b0, 32'h0,        ID, 32'h0,   1'b1, 1'b0, ID, 32'h0,    2'b11, 2'b00, 1'b0, 32'h0);
    vt[6]  = mk(NS, 32'h2004, 1'b0, 32'h0,        NS, 32'h400, 1'b1, 1'b0, NS, 32'h2004, 2'b11, 2'b00, 1'b0, 32'h0);
    vt[7]  = mk(ID, 32'h0,    1'b0, 32'h0,        ID, 32'h0,   1'b0, 1'b0, NS, 32'h400,  2'b00, 2'b00, 1'b0, 32'h0);
    vt[8]  = mk(ID, 32'h0,    1'b0, 32'h0,        ID, 32'h0,   1'b0, 1'b0, NS, 32'h400,  2'b00, 2'b00, 1'b0, 32'h0);
    vt[9]  = mk(ID, 32'h0,    1'b0, 32'h0,        ID, 32'h0,   1'b1, 1'b0, NS, 32'h400,  2'b01, 2'b00, 1'b0, 32'h0);
    vt[10] = mk(ID, 32'h0,    1'b0, 32'h0,        ID, 32'h0,   1'b1, 1'b0, ID, 32'h0,    2'b11, 2'b00, 1'b0, 32'h0);
    vt[11] = mk(NS, 32'h2008, 1'b1, 32'h0,        NS, 32'h500, 1'b1, 1'b0, NS, 32'h2008, 2'b11, 2'b00, 1'b0, 32'h0);
    vt[12] = mk(ID, 32'h0,    1'b0, 32'h12345678, ID, 32'h0,   1'b0, 1'b1, NS, 32'h500,  2'b00, 2'b01, 1'b1, 32'h12345678);
    vt[13] = mk(ID, 32'h0,    1'b0, 32'h12345678, ID, 32'h0,   1'b1, 1'b1, NS, 32'h500,  2'b01, 2'b01, 1'b1, 32'h12345678);
    vt[14] = mk(ID, 32'h0,    1'b0, 32'h0,        ID, 32'h0,   1'b1, 1'b0, ID, 32'h0,    2'b11, 2'b00, 1'b0, 32'h0);

    // Reset state, with both masters requesting to show nothing leaks out.
    rst    = 1'b1;
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = 32'h0;
    drive_m(0, NS, 32'h40, 1'b0, 32'h0);
    drive_m(1, NS, 32'h80, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("reset htrans", htrans, ID);
    chk("reset m_hready", m_hready, 2'b11);
    chk("reset m_hresp", m_hresp, 2'b00);
    chk("reset hburst", hburst, YCR_HBURST_SINGLE);
    chk("reset hmastlock", hmastlock, 1'b0);
    drive_m(0, ID, 32'h0, 1'b0, 32'h0);
    drive_m(1, ID, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive_m(0, vt[i].t0, vt[i].a0, vt[i].w0, vt[i].d0);
      drive_m(1, vt[i].t1, vt[i].a1, 1'b0, 32'h0);
      hready = vt[i].hr;
      hresp  = vt[i].hrs;
      hrdata = 32'hC0DE_0000 + W'(i);
      #1;
      chk($sformatf("v%0d htrans", i), htrans, vt[i].e_trans);
      if (vt[i].e_trans == NS) chk($sformatf("v%0d haddr", i), haddr, vt[i].e_addr);
      chk($sformatf("v%0d m_hready", i), m_hready, vt[i].e_rdy);
      chk($sformatf("v%0d m_hresp", i), m_hresp, vt[i].e_resp);
      if (vt[i].chk_wd) chk($sformatf("v%0d hwdata", i), hwdata, vt[i].e_wd);
      chk($sformatf("v%0d m_hrdata0", i), m_hrdata[0], 32'hC0DE_0000 + W'(i));
      chk($sformatf("v%0d m_hrdata1", i), m_hrdata[1], 32'hC0DE_0000 + W'(i));
    end

    stream(32'h1000, 32'h600);
    stream(32'h3000, 32'h700);

    // Reset while master 1 is parked behind a stalled slave.
    @(negedge clk);
    drive_m(0, NS, 32'h2010, 1'b1, 32'h0);
    drive_m(1, NS, 32'h400, 1'b0, 32'h0);
    hready = 1'b1;
    #1;
    chk("rsthold first haddr", haddr, 32'h2010);
    @(negedge clk);
    drive_m(0, ID, 32'h0, 1'b0, 32'h0);
    drive_m(1, ID, 32'h0, 1'b0, 32'h0);
    hready = 1'b0;
    #1;
    chk("rsthold parked haddr", haddr, 32'h400);
    chk("rsthold parked m_hready", m_hready, 2'b00);
    rst = 1'b1;
    #1;
    chk("rsthold async htrans", htrans, ID);
    chk("rsthold async m_hready", m_hready, 2'b11);
    chk("rsthold async m_hresp", m_hresp, 2'b00);
    @(negedge clk);
    rst    = 1'b0;
    hready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rsthold after c%0d htrans", c), htrans, ID);
      chk($sformatf("rsthold after c%0d m_hready", c), m_hready, 2'b11);
    end

    // Randomized traffic against the reference model.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    busy   = -1;
    lock   = -1;
    streak = 0;
    for (int x = 0; x < 2; x++) begin
      held[x]   = 1'b0;
      adv[x]    = 1'b1;
      nxt_wd[x] = 32'h0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int x = 0; x < 2; x++) begin
        if (adv[x]) begin
          cur[x].t = ($urandom_range(0, 9) < 6) ? NS : ID;
          cur[x].a = W'($urandom) & ~W'(3);
          cur[x].w = 1'($urandom);
          cur[x].s = 3'($urandom_range(0, 2));
          cur[x].p = 4'($urandom);
          cur[x].d = W'($urandom);
        end
        m_htrans[x] = cur[x].t;
        m_haddr[x]  = cur[x].a;
        m_hwrite[x] = cur[x].w;
        m_hsize[x]  = cur[x].s;
        m_hprot[x]  = cur[x].p;
        m_hwdata[x] = nxt_wd[x];
      end
      hready = ($urandom_range(0, 3) != 0);
      hresp  = ($urandom_range(0, 7) == 0);
      hrdata = W'($urandom);
      #1;
      for (int x = 0; x < 2; x++) begin
        e_rdy[x] = held[x] ? 1'b0 : ((busy == x) ? hready : 1'b1);
        live[x]  = e_rdy[x] && (cur[x].t == NS);
        want[x]  = held[x] || live[x];
      end
      win = lock;
      if (win < 0) begin
        if (want[0] && !(streak >= MAXC && want[1])) win = 0;
        else if (want[1])                            win = 1;
      end
      chk("rnd htrans", htrans, (win >= 0) ? NS : ID);
      if (win >= 0) begin
        src = held[win] ? held_c[win] : cur[win];
        chk("rnd haddr", haddr, src.a);
        chk("rnd hwrite", hwrite, src.w);
        chk("rnd hsize", hsize, src.s);
        chk("rnd hprot", hprot, src.p);
      end
      chk("rnd m_hready", m_hready, e_rdy);
      chk("rnd m_hresp", m_hresp, {(busy == 1) && hresp, (busy == 0) && hresp});
      if (busy >= 0) chk("rnd hwdata", hwdata, nxt_wd[busy]);

      took = hready && (win >= 0);
      for (int x = 0; x < 2; x++) begin
        if (took && win == x) begin
          held[x] = 1'b0;
        end else if (live[x]) begin
          held[x]   = 1'b1;
          held_c[x] = cur[x];
        end
      end
      if (!want[1])  streak = 0;
      else if (took) streak = (win == 1) ? 0 : streak + 1;
      if (hready) busy = took ? win : -1;
      lock = (!hready && win >= 0) ? win : -1;
      for (int x = 0; x < 2; x++) begin
        adv[x] = e_rdy[x];
        if (e_rdy[x] && cur[x].t == NS && cur[x].w) nxt_wd[x] = cur[x].d;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
